// File: rtl/ram_port_pkg.sv
// Shared types and lane helpers for the RAM port master: size encoding, FSM states,
// byte-enable generation, store replication and load extraction.
package ram_port_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    function automatic logic req_err(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_HALF: req_err = a[0];
            SZ_WORD: req_err = (a != 2'b00);
            SZ_ILL:  req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: lane_be = 4'b0001 << a;
            SZ_HALF: lane_be = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: store_data = {4{d[7:0]}};
            SZ_HALF: store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // Right-justify the addressed lane(s) of a RAM word, with optional sign extension.
    function automatic logic [31:0] load_extract(input logic [31:0] d, input size_e sz,
                                                 input logic [1:0] a, input logic sgn);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = d >> {a, 3'b000};
        half    = a[1] ? d[31:16] : d[15:0];
        case (sz)
            SZ_BYTE: load_extract = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_extract = {{16{sgn & half[15]}}, half};
            default: load_extract = d;
        endcase
    endfunction

endpackage

// File: rtl/ram_port_master.sv
// Single-request load/store master that drives a synchronous single-port RAM.
//   state | meaning
//   IDLE  | ready_o=1, waiting for req_i
//   ISSUE | RAM address/enables/data on the port, ram_we_o=1 for stores
//   WAIT  | load only: RAM read data returning, captured at end of state
//   RESP  | done_o pulse (err_o valid), then back to IDLE
module ram_port_master
    import ram_port_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    output logic              ready_o,
    input  logic              we_i,
    input  logic [ADDR_W+1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [31:0]       wdata_i,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_adr_o,
    output logic [3:0]        ram_be_o,
    output logic [31:0]       ram_dat_o,
    input  logic [31:0]       ram_dat_i
);

    state_e     state;
    logic       we_q;
    logic       sgn_q;
    size_e      size_q;
    logic [1:0] lane_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            ready_o   <= 1'b1;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
            ram_we_o  <= 1'b0;
            ram_adr_o <= '0;
            ram_be_o  <= '0;
            ram_dat_o <= '0;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            size_q    <= SZ_BYTE;
            lane_q    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        ready_o <= 1'b0;
                        we_q    <= we_i;
                        sgn_q   <= signed_i;
                        size_q  <= size_e'(size_i);
                        lane_q  <= addr_i[1:0];
                        if (req_err(size_e'(size_i), addr_i[1:0])) begin
                            state  <= RESP;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            err_o     <= 1'b0;
                            ram_we_o  <= we_i;
                            ram_adr_o <= addr_i[ADDR_W+1:2];
                            ram_be_o  <= lane_be(size_e'(size_i), addr_i[1:0]);
                            ram_dat_o <= store_data(size_e'(size_i), wdata_i);
                        end
                    end
                end
                ISSUE: begin
                    ram_we_o <= 1'b0;
                    ram_be_o <= '0;
                    if (we_q) begin
                        state  <= RESP;
                        done_o <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rdata_o <= load_extract(ram_dat_i, size_q, lane_q, sgn_q);
                    state   <= RESP;
                    done_o  <= 1'b1;
                end
                RESP: begin
                    state   <= IDLE;
                    err_o   <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_master.sv
// Scoreboard bench for ram_port_master with a behavioural synchronous RAM and a reference memory.
module tb_ram_port_master;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [13:0] addr_i = '0;
    logic [1:0]  size_i = '0;
    logic        signed_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        ready_o, done_o, err_o, ram_we_o;
    logic [31:0] rdata_o, ram_dat_o;
    logic [31:0] ram_dat_i = '0;
    logic [11:0] ram_adr_o;
    logic [3:0]  ram_be_o;

    ram_port_master #(.ADDR_W(12)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .ready_o(ready_o),
        .we_i(we_i), .addr_i(addr_i), .size_i(size_i), .signed_i(signed_i),
        .wdata_i(wdata_i), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .ram_we_o(ram_we_o), .ram_adr_o(ram_adr_o), .ram_be_o(ram_be_o),
        .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } resp_t;

    typedef struct {
        logic [11:0] adr;
        logic [3:0]  be;
        logic [31:0] dat;
    } wr_t;

    resp_t       rsp_q[$];
    wr_t         wr_q[$];
    resp_t       mon_r;
    wr_t         mon_w;
    logic [31:0] mem [4096];
    logic [31:0] model_mem [4096];
    logic [31:0] exp_rdata = '0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk_i) begin
        cyc++;
        if (ram_we_o) begin
            for (int i = 0; i < 4; i++)
                if (ram_be_o[i]) mem[ram_adr_o][8*i +: 8] <= ram_dat_o[8*i +: 8];
        end
        ram_dat_i <= mem[ram_adr_o];
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (ram_we_o) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'(ram_adr_o), 32'hFFFF_FFFF);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_adr", 32'(ram_adr_o), 32'(mon_w.adr));
                    chk("wr_be", 32'(ram_be_o), 32'(mon_w.be));
                    chk("wr_dat", ram_dat_o, mon_w.dat);
                end
            end
            if (done_o) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done_o), 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("err", 32'(err_o), 32'(mon_r.err));
                    chk("rdata", rdata_o, mon_r.rdata);
                    chk("latency", 32'(cyc - acc_cyc + 1), 32'(mon_r.lat));
                end
            end
        end
    end

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic sgn);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * int'(a))) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        if (!ready_o) chk("ready_timeout", 32'(ready_o), 32'd1);
    endtask

    // Call at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input logic we, input logic [13:0] addr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] wd, input logic hold);
        logic        bad;
        logic [3:0]  be;
        logic [31:0] dat;
        int          idx;
        wait_ready();
        bad = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
        idx = int'(addr[13:2]);
        we_i = we; addr_i = addr; size_i = sz; signed_i = sgn; wdata_i = wd;
        req_i = 1'b1;
        acc_cyc = cyc + 1;
        if (bad) begin
            rsp_q.push_back('{1'b1, exp_rdata, 1});
        end else if (we) begin
            case (sz)
                2'd0: begin be = 4'b0001 << addr[1:0]; dat = {4{wd[7:0]}}; end
                2'd1: begin be = addr[1] ? 4'b1100 : 4'b0011; dat = {2{wd[15:0]}}; end
                default: begin be = 4'b1111; dat = wd; end
            endcase
            wr_q.push_back('{addr[13:2], be, dat});
            for (int i = 0; i < 4; i++)
                if (be[i]) model_mem[idx][8*i +: 8] = dat[8*i +: 8];
            rsp_q.push_back('{1'b0, exp_rdata, 2});
        end else begin
            exp_rdata = f_load(model_mem[idx], sz, addr[1:0], sgn);
            rsp_q.push_back('{1'b0, exp_rdata, 3});
        end
        @(posedge clk_i);
        @(negedge clk_i);
        if (!hold) req_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (rsp_q.size() != 0 && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (rsp_q.size() != 0) chk("drain_timeout", 32'(rsp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = '0;
            model_mem[i] = '0;
        end
        mem[0] = 32'h8001_1234;
        model_mem[0] = 32'h8001_1234;

        #12;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_we", 32'(ram_we_o), 32'd0);
        chk("rst_be", 32'(ram_be_o), 32'd0);
        chk("rst_adr", 32'(ram_adr_o), 32'd0);
        chk("rst_dat", ram_dat_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        issue(1'b1, 14'h010, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 14'h013, 2'd0, 1'b0, 32'h0000_00A5, 1'b0);
        issue(1'b0, 14'h013, 2'd0, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 14'h013, 2'd0, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 14'h002, 2'd1, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 14'h002, 2'd1, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 14'h006, 2'd2, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 14'h000, 2'd3, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 14'h021, 2'd1, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 14'h02A, 2'd1, 1'b0, 32'h1234_ABCD, 1'b0);
        issue(1'b0, 14'h028, 2'd2, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 14'h010, 2'd1, 1'b1, 32'h0, 1'b0);
        drain();

        // Abort a store while it is on the RAM port.
        saved = model_mem[32];
        issue(1'b1, 14'h080, 2'd2, 1'b0, 32'h1111_2222, 1'b0);
        chk("abort_we_before", 32'(ram_we_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("abort_we", 32'(ram_we_o), 32'd0);
        chk("abort_ready", 32'(ready_o), 32'd1);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_rdata", rdata_o, 32'd0);
        rsp_q.delete();
        wr_q.delete();
        model_mem[32] = saved;
        exp_rdata = '0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        issue(1'b0, 14'h080, 2'd2, 1'b0, 32'h0, 1'b0);
        drain();

        // Continuous request: each completion admits exactly one new request.
        for (int k = 0; k < 4; k++)
            issue(1'b1, 14'(14'h100 + 4 * k), 2'd2, 1'b0, 32'hC0DE_0000 + 32'(k), (k != 3));
        drain();
        for (int k = 0; k < 4; k++)
            issue(1'b0, 14'(14'h100 + 4 * k), 2'd2, 1'b0, 32'h0, 1'b0);
        drain();

        for (int k = 0; k < 30; k++)
            issue(1'($urandom_range(0, 1)), 14'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
        drain();
        repeat (3) @(negedge clk_i);
        chk("writes_pending", 32'(wr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
